// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and lane helpers for the memory access unit
// Purpose: size encodings, FSM state type, and byte-lane helper functions
//          used by mem_access_unit and load_align.
// Ports:   none (package).
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is handled as a word too

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Byte enables for a store of the given size starting at byte lane `lane`.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 4'b0001 << lane;
      SIZE_HALF: return 4'b0011 << lane;
      default:   return 4'b1111;
    endcase
  endfunction

  // Halfwords must sit on an even lane, words on lane 0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      default:   return (lane != 2'b00);
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in, so the
  // byte enables alone select the destination.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane extraction with sign/zero extension
// Purpose: pick the addressed byte/halfword out of a fetched word and extend it.
// Ports:   rdata  - fetched memory word
//          lane   - byte address bits [1:0]
//          size   - access size encoding
//          sign   - 1 sign-extends, 0 zero-extends
//          result - 32-bit aligned load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0; the low bits then hold the datum.
  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    result = rdata;
    case (size)
      SIZE_BYTE: result = {{24{sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store controller with wait states
// Purpose: turns an ALU byte address plus store operand into a word-addressed
//          memory request, stalls the pipeline until the memory answers,
//          returns aligned load data, flags misalignment and bus timeouts.
// Ports:   clk, reset (async, active-high)
//          mem_read_i/mem_write_i/size_i/sign_ext_i/alu_result_i/write_data_i - request
//          mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o - memory request side
//          mem_ready_i/mem_rdata_i - memory response side
//          stall_o/valid_o/read_data_o/fault_o/bus_error_o - pipeline status/result
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] read_data_o,
  output logic        fault_o,
  output logic        bus_error_o
);

  // Keep at least one counter bit so a disabled timeout still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, done_ok, done_to;
  logic          misaligned;
  logic [1:0]    size_q, lane_q;
  logic          sign_q;
  logic [31:0]   align_data;

  assign misaligned = is_misaligned(size_i, alu_result_i[1:0]);

  load_align u_load_align (
    .rdata  (mem_rdata_i),
    .lane   (lane_q),
    .size   (size_q),
    .sign   (sign_q),
    .result (align_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    fault_o   = 1'b0;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    valid_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_read_i | mem_write_i) begin
          if (misaligned) begin
            fault_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            accept    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          done_ok   = 1'b1;
          state_nxt = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1))) begin
          // This wait cycle brings the count to TIMEOUT_CYCLES.
          done_to   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE: begin
        valid_o   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request is captured once on IDLE->REQ and held stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      size_q      <= SIZE_BYTE;
      lane_q      <= 2'b00;
      sign_q      <= 1'b0;
    end else if (accept) begin
      mem_we_o    <= mem_write_i;
      mem_addr_o  <= {alu_result_i[31:2], 2'b00};
      mem_be_o    <= mem_write_i ? lane_be(size_i, alu_result_i[1:0]) : 4'b1111;
      mem_wdata_o <= store_wdata(size_i, write_data_i);
      size_q      <= size_i;
      lane_q      <= alu_result_i[1:0];
      sign_q      <= sign_ext_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_o <= '0;
      bus_error_o <= 1'b0;
    end else begin
      // Only set on the REQ->DONE timeout edge, so it pulses during DONE.
      bus_error_o <= done_to;
      if (done_to) begin
        read_data_o <= '0;
      end else if (done_ok && !mem_we_o) begin
        read_data_o <= align_data;
      end
    end
  end

endmodule
